m_matkey_scan: RTL and testbench

- Scans a 4x4 matrix keypad and debounces it.
- Produces a 4-bit key code plus a held flag, which drive the team's matrix-key 7-segment display path (code into data input, flag into display-enable input).
- Drives rows active-low one at a time and samples active-low, externally pulled-up columns.
- Sits between the keypad pins and the display/logic that consumes key presses.

---
 rtl/m_matkey_scan_pkg.sv | 32 +++
 rtl/m_matkey_scan_if.sv | 14 +
 rtl/m_matkey_scan_tick.sv | 23 ++
 rtl/m_matkey_scan.sv | 129 ++++++++++++
 tb/tb_m_matkey_scan.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/m_matkey_scan_pkg.sv
// Shared constants, types and helpers for the matrix keypad scanner.
// Any block that consumes key codes or row drive patterns can import this package.
package m_matkey_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  localparam logic [KEY_ROWS-1:0] ROW_IDLE   = 4'b1111;
  localparam logic [KEY_ROWS-1:0] ROW0_DRIVE = 4'b1110;

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } row_state_t;

  typedef struct packed {
    logic                  hit;
    logic [KEY_CODE_W-1:0] code;
  } scan_res_t;

  // Column 0 has the highest priority, so a lower code always wins.
  function automatic logic [1:0] lowest_col(input logic [KEY_COLS-1:0] col);
    if (col[0])      return 2'd0;
    else if (col[1]) return 2'd1;
    else if (col[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/m_matkey_scan_if.sv
// Keypad pin and key-event bundle. The slave side is the scanner;
// the master side is the keypad and display logic.
interface m_matkey_scan_if;
  import m_matkey_pkg::*;

  logic [KEY_ROWS-1:0]   key_row;
  logic [KEY_COLS-1:0]   key_col;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  pushed;
  logic                  key_valid;

  modport slave  (output key_row, key_code, pushed, key_valid, input  key_col);
  modport master (input  key_row, key_code, pushed, key_valid, output key_col);
endinterface

// File: rtl/m_matkey_scan_tick.sv
// Free-running divider that emits a one-cycle tick every SCAN_DIV+1 clocks.
// It is not tied to the keypad and can pace any scanned peripheral.
module m_scan_tick #(
  parameter int unsigned SCAN_DIV = 49999
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [19:0] DIV = 20'(SCAN_DIV);

  logic [19:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (cnt == DIV) cnt <= '0;
    else                 cnt <= cnt + 20'd1;
  end

  assign tick = (cnt == DIV);

endmodule

// File: rtl/m_matkey_scan.sv
// 4x4 matrix keypad scanner: row drive, column synchronizer, frame priority
// encoder and frame-level debounce producing key_code / pushed / key_valid.
//
// state | meaning
// ROW0  | row 0 driven low, sampled on next tick
// ROW1  | row 1 driven low, sampled on next tick
// ROW2  | row 2 driven low, sampled on next tick
// ROW3  | row 3 driven low, its tick closes the frame
module m_matkey_scan
  import m_matkey_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 49999,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            rst,
  m_matkey_scan_if.slave  bus
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic                tick;
  logic [KEY_COLS-1:0] col_meta;
  logic [KEY_COLS-1:0] col_sync;
  logic [KEY_COLS-1:0] col_s;
  row_state_t          row;
  row_state_t          row_nxt;
  logic                frame_end;
  scan_res_t           sample;
  scan_res_t           acc;
  scan_res_t           frame_res;
  scan_res_t           cand;
  logic [3:0]          stab_cnt;
  logic [3:0]          stab_nxt;
  logic                same;
  logic                accept;

  m_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= bus.key_col;
      col_sync <= col_meta;
    end
  end

  assign col_s = ~col_sync;

  always_ff @(posedge clk) begin
    if (rst) row <= ROW0;
    else     row <= row_nxt;
  end

  always_comb begin
    row_nxt = row;
    if (tick) begin
      case (row)
        ROW0:    row_nxt = ROW1;
        ROW1:    row_nxt = ROW2;
        ROW2:    row_nxt = ROW3;
        default: row_nxt = ROW0;
      endcase
    end
  end

  always_comb begin
    bus.key_row = ROW_IDLE;
    case (row)
      ROW0:    bus.key_row = ROW0_DRIVE;
      ROW1:    bus.key_row = 4'b1101;
      ROW2:    bus.key_row = 4'b1011;
      default: bus.key_row = 4'b0111;
    endcase
  end

  assign frame_end   = tick && (row == ROW3);
  assign sample.hit  = (col_s != '0);
  assign sample.code = sample.hit ? {2'(row), lowest_col(col_s)} : '0;
  // The first hit of the frame sticks; the row-3 sample only counts if nothing came earlier.
  assign frame_res   = acc.hit ? acc : sample;

  always_ff @(posedge clk) begin
    if (rst)                         acc <= '0;
    else if (frame_end)              acc <= '0;
    else if (tick && !acc.hit && sample.hit) acc <= sample;
  end

  always_comb begin
    same = (frame_res.hit == cand.hit) &&
           (!frame_res.hit || (frame_res.code == cand.code));
    if (same) stab_nxt = (stab_cnt >= DEB) ? DEB : 4'(stab_cnt + 4'd1);
    else      stab_nxt = 4'd1;
    // Fire only on the frame where the count reaches DEB, not while it sits saturated.
    accept = frame_end && (stab_nxt == DEB) && (!same || (stab_cnt != DEB));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand          <= '0;
      stab_cnt      <= '0;
      bus.key_code  <= '0;
      bus.pushed    <= 1'b0;
      bus.key_valid <= 1'b0;
    end else begin
      bus.key_valid <= 1'b0;
      if (frame_end) begin
        cand     <= frame_res;
        stab_cnt <= stab_nxt;
        if (accept) begin
          if (frame_res.hit) begin
            bus.key_code  <= frame_res.code;
            bus.pushed    <= 1'b1;
            bus.key_valid <= !bus.pushed || (bus.key_code != frame_res.code);
          end else begin
            bus.pushed    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_m_matkey_scan.sv
// Bench for m_matkey_scan: a keypad model drives the columns, and a frame-level
// reference model predicts every output on every cycle, with directed and random presses.
module tb_m_matkey_scan;

  localparam int SD    = 3;
  localparam int DB    = 4;
  localparam int DWELL = SD + 1;
  localparam int FRAME = 4 * DWELL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  col_drive;

  always #5 clk = ~clk;

  m_matkey_scan_if bus();

  m_matkey_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    col_drive = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bus.key_row[r] && pressed[r*4+c]) col_drive[c] = 1'b0;
  end
  assign bus.key_col = col_drive;

  int         errors = 0;
  int         checks = 0;
  int         pulses = 0;
  bit         chk_en = 1'b0;
  int         k = 0;
  logic       m_cand_hit = 1'b0;
  logic [3:0] m_cand_code = '0;
  int         m_stab = 0;
  logic [3:0] m_code = '0;
  logic       m_pushed = 1'b0;
  logic       m_valid = 1'b0;
  logic [3:0] m_row = 4'b1110;
  logic [3:0] row_tab [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: the whole frame sees one key set, so its result is
  // simply the lowest pressed code.
  task automatic model_frame_end();
    logic       hit;
    logic [3:0] code;
    bit         acc;
    hit = 1'b0;
    code = '0;
    for (int i = 15; i >= 0; i--)
      if (pressed[i]) begin hit = 1'b1; code = 4'(i); end
    if (hit == m_cand_hit && (!hit || code == m_cand_code)) begin
      acc = (m_stab == DB - 1);
      if (m_stab < DB) m_stab++;
    end else begin
      m_cand_hit = hit;
      m_cand_code = code;
      m_stab = 1;
      acc = (DB == 1);
    end
    if (acc) begin
      if (m_cand_hit) begin
        m_valid = !m_pushed || (m_code != m_cand_code);
        m_code = m_cand_code;
        m_pushed = 1'b1;
      end else begin
        m_pushed = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      k = 0;
      m_cand_hit = 1'b0;
      m_cand_code = '0;
      m_stab = 0;
      m_code = '0;
      m_pushed = 1'b0;
      m_valid = 1'b0;
    end else begin
      k++;
      m_valid = 1'b0;
      if (k % FRAME == 0) model_frame_end();
    end
    m_row = ~(4'b0001 << ((k / DWELL) % 4));
    #1;
    if (bus.key_valid) pulses++;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic frames(input logic [15:0] m, input int nf);
    pressed = m;
    cycles(nf * FRAME);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("key_row",   int'(bus.key_row),   int'(m_row));
      check("key_code",  int'(bus.key_code),  int'(m_code));
      check("pushed",    int'(bus.pushed),    int'(m_pushed));
      check("key_valid", int'(bus.key_valid), int'(m_valid));
    end
  end

  initial begin
    logic [15:0] m;
    int          nk;
    row_tab[0] = 4'b1110;
    row_tab[1] = 4'b1101;
    row_tab[2] = 4'b1011;
    row_tab[3] = 4'b0111;

    // reset hold
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cycles(9);
    check("rst_key_row",   int'(bus.key_row),   4'b1110);
    check("rst_key_code",  int'(bus.key_code),  0);
    check("rst_pushed",    int'(bus.pushed),    0);
    check("rst_key_valid", int'(bus.key_valid), 0);
    rst = 1'b0;

    // idle row rotation
    pressed = '0;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      check("idle_row_seq", int'(bus.key_row), int'(row_tab[((i + 1) / DWELL) % 4]));
    end
    frames('0, 3);
    check("idle_pushed", int'(bus.pushed), 0);

    // (1,1) held: acceptance exactly after 4 frames
    pulses = 0;
    pressed = 16'h0020;
    cycles(4 * FRAME - 1);
    check("k5_early_pushed", int'(bus.pushed), 0);
    cyc();
    check("k5_pushed",    int'(bus.pushed),    1);
    check("k5_code",      int'(bus.key_code),  5);
    check("k5_valid",     int'(bus.key_valid), 1);
    frames(16'h0020, 4);
    check("k5_pulses", pulses, 1);

    frames('0, 4);
    check("k5_release", int'(bus.pushed), 0);

    // (3,3) bouncing every frame
    pulses = 0;
    for (int f = 0; f < 10; f++) begin
      frames((f % 2 == 0) ? 16'h8000 : 16'h0000, 1);
      check("bounce_pushed", int'(bus.pushed), 0);
    end
    check("bounce_pulses", pulses, 0);

    // (3,3) held then released
    frames(16'h8000, 4);
    check("k15_code",   int'(bus.key_code), 15);
    check("k15_pushed", int'(bus.pushed),   1);
    frames('0, 3);
    check("k15_rel_hold", int'(bus.pushed), 1);
    frames('0, 1);
    check("k15_rel_pushed", int'(bus.pushed),   0);
    check("k15_rel_code",   int'(bus.key_code), 15);

    // (0,2)+(2,1) priority, then hand over to (2,1)
    frames(16'h0204, 4);
    check("prio_code", int'(bus.key_code), 2);
    pulses = 0;
    for (int f = 0; f < 4; f++) begin
      frames(16'h0200, 1);
      check("chg_pushed", int'(bus.pushed), 1);
    end
    check("chg_code",   int'(bus.key_code), 9);
    check("chg_pulses", pulses, 1);

    // (1,0) accepted, reset mid-frame, re-acquired
    frames('0, 4);
    frames(16'h0010, 4);
    check("k4_code", int'(bus.key_code), 4);
    cycles(7);
    rst = 1'b1;
    cyc();
    check("mid_rst_key_row",  int'(bus.key_row),   4'b1110);
    check("mid_rst_key_code", int'(bus.key_code),  0);
    check("mid_rst_pushed",   int'(bus.pushed),    0);
    check("mid_rst_valid",    int'(bus.key_valid), 0);
    rst = 1'b0;
    pulses = 0;
    frames(16'h0010, 3);
    check("reacq_early", int'(bus.pushed), 0);
    frames(16'h0010, 1);
    check("reacq_pushed", int'(bus.pushed),   1);
    check("reacq_code",   int'(bus.key_code), 4);
    check("reacq_pulses", pulses, 1);

    // random key sets, mostly held across several frames
    m = '0;
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 9) < 2) begin
        m = '0;
        nk = $urandom_range(0, 2);
        for (int j = 0; j < nk; j++) m[$urandom_range(0, 15)] = 1'b1;
      end
      frames(m, 1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
